ddr5_cmd_issuer: RTL

Consumer end of the trace-request path: accepts parsed CPU requests (cycle, core, operation, address) into an internal queue and drains them in order, converting each into timed DDR5 ACT / RD / WR / PRE commands. Sits between the trace front end, which pushes requests while the queue has room, and the DIMM command output. It enforces tRCD, tCL, tCWL, burst, and tRP spacing with down-counters.

---
 rtl/ddr5_cmd_issuer_pkg.sv | 37 +++
 rtl/ddr5_req_fifo.sv | 56 +++++
 rtl/ddr5_cmd_issuer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ddr5_cmd_issuer_pkg.sv
// Shared types for the DDR5 command issuer: command/op encodings, the queued
// request layout and the address-field bit positions.
package ddr5_cmd_issuer_pkg;
  typedef enum logic [2:0] {
    CMD_NOP = 3'd0, CMD_ACT = 3'd1, CMD_RD = 3'd2, CMD_WR = 3'd3, CMD_PRE = 3'd4
  } cmd_t;

  typedef enum logic [1:0] {
    OP_RD = 2'd0, OP_WR = 2'd1, OP_IFETCH = 2'd2, OP_ILLEGAL = 2'd3
  } op_t;

  typedef struct packed {
    logic [63:0] cycle;
    logic [3:0]  core;
    op_t         op;
    logic [33:0] addr;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  localparam int ROW_HI  = 33, ROW_LO  = 18;
  localparam int COLH_HI = 17, COLH_LO = 12;
  localparam int BA_HI   = 11, BA_LO   = 10;
  localparam int BG_HI   = 9,  BG_LO   = 7;
  localparam int COLL_HI = 5,  COLL_LO = 2;

  localparam int DEF_QUEUE_DEPTH = 16;
  localparam int DEF_TRCD   = 39;
  localparam int DEF_TCL    = 40;
  localparam int DEF_TCWL   = 38;
  localparam int DEF_TBURST = 8;
  localparam int DEF_TRP    = 39;

  function automatic logic [9:0] addr_col(input logic [33:0] a);
    return {a[COLH_HI:COLH_LO], a[COLL_HI:COLL_LO]};
  endfunction
endpackage

// File: rtl/ddr5_req_fifo.sv
// Request queue: power-of-two circular buffer with registered count and full.
module ddr5_req_fifo import ddr5_cmd_issuer_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [REQ_W-1:0]         din,
  output logic [REQ_W-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [REQ_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             r_full;
  logic             w_push, w_pop;

  assign w_push = push && !r_full;
  assign w_pop  = pop && (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10: begin
          r_count <= r_count + 1'b1;
          r_full  <= (r_count == (AW+1)'(DEPTH-1));
        end
        2'b01: begin
          r_count <= r_count - 1'b1;
          r_full  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= din;

  assign dout  = r_mem[r_rptr];
  assign full  = r_full;
  assign empty = (r_count == '0);
  assign count = r_count;
endmodule

// File: rtl/ddr5_cmd_issuer.sv
// Drains queued CPU requests in order into timed ACT/RD/WR/PRE commands.
// Define DDR5_OPEN_PAGE_EN for the open-page policy (open-row table, no auto-PRE).
module ddr5_cmd_issuer import ddr5_cmd_issuer_pkg::*; #(
  parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
  parameter int TRCD        = DEF_TRCD,
  parameter int TCL         = DEF_TCL,
  parameter int TCWL        = DEF_TCWL,
  parameter int TBURST      = DEF_TBURST,
  parameter int TRP         = DEF_TRP
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [63:0]                    req_cycle,
  input  logic [3:0]                     req_core,
  input  logic [1:0]                     req_op,
  input  logic [33:0]                    req_addr,
  output logic                           cmd_valid,
  output logic [2:0]                     cmd,
  output logic [2:0]                     cmd_bg,
  output logic [1:0]                     cmd_ba,
  output logic [15:0]                    cmd_row,
  output logic [9:0]                     cmd_col,
  output logic                           done,
  output logic                           err,
  output logic [$clog2(QUEUE_DEPTH):0]   q_count
);
  localparam int CW = 16;
  localparam logic [2:0] S_IDLE = 3'd0, S_ACT = 3'd1, S_WAIT_RCD = 3'd2, S_RDWR = 3'd3,
                         S_WAIT_DATA = 3'd4, S_PRE = 3'd5, S_WAIT_RP = 3'd6;

  logic [REQ_W-1:0] w_head_bits;
  req_t             w_head;
  logic             w_full, w_empty, w_pop;
  logic [2:0]       r_state;
  logic [CW-1:0]    r_cnt, w_cnt_dec;
  logic             w_cnt_last, w_is_wr, w_illegal;
  logic [2:0]       w_bg;
  logic [1:0]       w_ba;
  logic [15:0]      w_row;
  logic             r_cmd_valid, r_done, r_err;
  logic [2:0]       r_cmd, r_bg;
  logic [1:0]       r_ba;
  logic [15:0]      r_row;
  logic [9:0]       r_col;
  logic             w_unused;

  ddr5_req_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk(clk), .rst(rst),
    .push(req_valid), .pop(w_pop),
    .din({req_cycle, req_core, req_op, req_addr}),
    .dout(w_head_bits), .full(w_full), .empty(w_empty), .count(q_count)
  );

  assign w_head    = w_head_bits;
  assign w_bg      = w_head.addr[BG_HI:BG_LO];
  assign w_ba      = w_head.addr[BA_HI:BA_LO];
  assign w_row     = w_head.addr[ROW_HI:ROW_LO];
  assign w_is_wr   = (w_head.op == OP_WR);
  assign w_illegal = (w_head.op == OP_ILLEGAL);
  assign w_pop     = (r_state == S_RDWR) || (r_state == S_IDLE && !w_empty && w_illegal);
  assign w_unused  = ^{w_head.cycle, w_head.core, w_head.addr[6], w_head.addr[1:0]};

  // The command is registered on the edge that leaves the issuing state, so the
  // spacing waits exit one count early to land the next command exactly tX later.
  assign w_cnt_last = (r_cnt <= CW'(1));
  assign w_cnt_dec  = (r_cnt == '0) ? '0 : r_cnt - CW'(1);

`ifdef DDR5_OPEN_PAGE_EN
  logic [31:0] r_open_vld;
  logic [15:0] r_open_row [32];
  logic [4:0]  w_bank;
  logic        w_hit, w_conflict;

  assign w_bank     = {w_bg, w_ba};
  assign w_hit      = r_open_vld[w_bank] && (r_open_row[w_bank] == w_row);
  assign w_conflict = r_open_vld[w_bank] && !w_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_open_vld         <= '0;
    else if (r_state == S_ACT)  r_open_vld[w_bank] <= 1'b1;
    else if (r_state == S_PRE)  r_open_vld[w_bank] <= 1'b0;
  end

  always_ff @(posedge clk)
    if (r_state == S_ACT) r_open_row[w_bank] <= w_row;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd       <= CMD_NOP;
      r_bg        <= '0;
      r_ba        <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_cmd       <= CMD_NOP;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_IDLE: if (!w_empty) begin
          if (w_illegal) r_err <= 1'b1;
`ifdef DDR5_OPEN_PAGE_EN
          else if (w_hit)      r_state <= S_RDWR;
          else if (w_conflict) r_state <= S_PRE;
`endif
          else r_state <= S_ACT;
        end
        S_ACT: begin
          r_cmd_valid <= 1'b1;
          r_cmd       <= CMD_ACT;
          r_bg        <= w_bg;
          r_ba        <= w_ba;
          r_row       <= w_row;
          r_cnt       <= CW'(TRCD-1);
          r_state     <= S_WAIT_RCD;
        end
        S_WAIT_RCD: begin
          r_cnt <= w_cnt_dec;
          if (w_cnt_last) r_state <= S_RDWR;
        end
        S_RDWR: begin
          r_cmd_valid <= 1'b1;
          r_cmd       <= w_is_wr ? CMD_WR : CMD_RD;
          r_bg        <= w_bg;
          r_ba        <= w_ba;
          r_col       <= addr_col(w_head.addr);
          r_cnt       <= w_is_wr ? CW'(TCWL+TBURST-1) : CW'(TCL+TBURST-1);
          r_state     <= S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          if (r_cnt == '0) begin
            r_done <= 1'b1;
`ifdef DDR5_OPEN_PAGE_EN
            r_state <= S_IDLE;
`else
            r_state <= S_PRE;
`endif
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_PRE: begin
          r_cmd_valid <= 1'b1;
          r_cmd       <= CMD_PRE;
`ifdef DDR5_OPEN_PAGE_EN
          // Conflict close: the head is still queued and names the bank to shut.
          r_bg        <= w_bg;
          r_ba        <= w_ba;
`endif
          r_cnt       <= CW'(TRP-1);
          r_state     <= S_WAIT_RP;
        end
        S_WAIT_RP: begin
          r_cnt <= w_cnt_dec;
`ifdef DDR5_OPEN_PAGE_EN
          if (w_cnt_last) r_state <= S_ACT;
`else
          if (w_cnt_last) r_state <= S_IDLE;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = !w_full;
  assign cmd_valid = r_cmd_valid;
  assign cmd       = r_cmd;
  assign cmd_bg    = r_bg;
  assign cmd_ba    = r_ba;
  assign cmd_row   = r_row;
  assign cmd_col   = r_col;
  assign done      = r_done;
  assign err       = r_err;
endmodule
